// File: rtl/sram_pkg.sv
// Shared types and default parameters for the MEM-stage SRAM controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int unsigned DEFAULT_BASE_ADDR   = 1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned DEFAULT_ADDR_W      = 18;

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int unsigned count_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one half-word phase: counts 0..WAIT_CYCLES, then wraps.
module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rest,
    input  logic clear,
    output logic terminal
);

    localparam int unsigned      CNT_W   = count_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0] count;

    // Wrapping on terminal lets the HIGH phase start from zero with no extra clear.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            count <= '0;
        end else if (clear || terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_MAX);

endmodule

// File: rtl/sram_controller.sv
// Sequences one 32-bit load/store as two half-word cycles on a 16-bit async SRAM,
// holding ready low to freeze the pipeline until the access completes.
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);

    sram_state_t       state;
    sram_state_t       state_next;
    logic              request;
    logic              op_write;
    logic [ADDR_W-2:0] word_lat;
    logic [15:0]       wdata_hi;
    logic [31:0]       offset;
    logic [ADDR_W-2:0] word_in;
    logic              phase_done;
    logic              in_phase;
    logic              unused_offset_bits;

    assign request  = wr_en | rd_en;
    assign offset   = address - BASE_ADDR;
    assign word_in  = offset[ADDR_W:2];
    assign in_phase = (state == LOW) || (state == HIGH);
    // Byte-lane bits and out-of-range bits are dropped: addresses wrap silently.
    assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rest    (rest),
        .clear   (!in_phase),
        .terminal(phase_done)
    );

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = LOW;
            LOW:     if (phase_done) state_next = HIGH;
            HIGH:    if (phase_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            IDLE: ready = !request;
            LOW, HIGH: begin
                sram_we_n  = !op_write;
                sram_dq_oe = op_write;
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Address and store data are registered one edge ahead so they line up with each phase.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            op_write    <= 1'b0;
            word_lat    <= '0;
            wdata_hi    <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            read_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        op_write  <= wr_en;
                        word_lat  <= word_in;
                        wdata_hi  <= write_data[31:16];
                        sram_addr <= {word_in, 1'b0};
                        if (wr_en) begin
                            sram_dq_out <= write_data[15:0];
                        end
                    end
                end
                LOW: begin
                    if (phase_done) begin
                        sram_addr <= {word_lat, 1'b1};
                        if (op_write) begin
                            sram_dq_out <= wdata_hi;
                        end else begin
                            read_data[15:0] <= sram_dq_in;
                        end
                    end
                end
                HIGH: begin
                    if (phase_done && !op_write) begin
                        read_data[31:16] <= sram_dq_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM, cycle-by-cycle bus checks, read-data scoreboard.
module tb_sram_controller;
    import sram_pkg::*;

    localparam int          W    = 2;
    localparam int          LAST = 2 * W + 3;
    localparam int unsigned BASE = 1024;
    localparam int          AW   = 18;

    logic          clk = 1'b0;
    logic          rest;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;
    logic          mem_clr;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_mem [0:63];
    logic [31:0] shadow   [0:31];
    logic [31:0] exp_q[$];
    logic [31:0] last_read;

    sram_controller #(
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(W),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rest       (rest),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= 16'h0000;
        end else if (!sram_we_n) begin
            sram_mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    // One complete access starting at the beginning of its cycle 0; returns at the start
    // of the IDLE cycle after DONE with the request removed.
    task automatic run_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input int drop_at, input string tag);
        logic [31:0]   off;
        logic [AW-1:0] wexp;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_rd;
        logic          exp_we_n;
        logic [15:0]   exp_dq;
        int            widx;
        bit            in_lo;
        bit            in_hi;
        off  = addr - BASE;
        wexp = AW'((off >> 2) << 1);
        widx = int'((off >> 2) & 32'd31);
        if (wr) shadow[widx] = data;
        else exp_q.push_back(shadow[widx]);
        wr_en      = wr;
        rd_en      = !wr;
        address    = addr;
        write_data = data;
        for (int c = 0; c <= LAST; c++) begin
            @(negedge clk);
            in_lo = (c >= 1) && (c <= W + 1);
            in_hi = (c >= W + 2) && (c <= 2 * W + 2);
            checks++;
            if (ready !== (c == LAST)) begin
                errors++;
                $display("FAIL %s ready c=%0d: got %b want %b", tag, c, ready, (c == LAST));
            end
            if (c >= 1) begin
                exp_addr = in_lo ? wexp : wexp + 1'b1;
                checks++;
                if (sram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL %s sram_addr c=%0d: got %0d want %0d", tag, c, sram_addr, exp_addr);
                end
            end
            exp_we_n = !(wr && (in_lo || in_hi));
            checks++;
            if (sram_we_n !== exp_we_n || sram_dq_oe !== !exp_we_n) begin
                errors++;
                $display("FAIL %s we_n/oe c=%0d: got %b/%b want %b/%b", tag, c, sram_we_n,
                         sram_dq_oe, exp_we_n, !exp_we_n);
            end
            if (wr && (in_lo || in_hi)) begin
                exp_dq = in_lo ? data[15:0] : data[31:16];
                checks++;
                if (sram_dq_out !== exp_dq) begin
                    errors++;
                    $display("FAIL %s dq_out c=%0d: got %h want %h", tag, c, sram_dq_out, exp_dq);
                end
            end
            if (c == LAST) begin
                checks++;
                if (dut.state !== DONE) begin
                    errors++;
                    $display("FAIL %s state at DONE cycle: got %0d want %0d", tag, dut.state, DONE);
                end
                if (wr) begin
                    exp_rd = last_read;
                end else if (exp_q.size() == 0) begin
                    exp_rd = 32'hxxxx_xxxx;
                    errors++;
                    $display("FAIL %s scoreboard empty: got %h want none", tag, read_data);
                end else begin
                    exp_rd = exp_q.pop_front();
                end
                checks++;
                if (read_data !== exp_rd) begin
                    errors++;
                    $display("FAIL %s read_data: got %h want %h", tag, read_data, exp_rd);
                end
                last_read = exp_rd;
            end
            if (c == drop_at) begin
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rest       = 1'b1;
        mem_clr    = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        last_read  = 32'h0;
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
        #2;
        checks++;
        if (read_data !== 32'h0 || sram_addr !== '0 || sram_dq_out !== 16'h0) begin
            errors++;
            $display("FAIL reset data regs: got rd=%h addr=%0d dq=%h want 0/0/0", read_data,
                     sram_addr, sram_dq_out);
        end
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset control: got we_n=%b oe=%b ready=%b want 1/0/1", sram_we_n,
                     sram_dq_oe, ready);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset state: got %0d want %0d", dut.state, IDLE);
        end
        repeat (2) @(posedge clk);
        #2;
        rest    = 1'b0;
        mem_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || dut.state !== IDLE) begin
                errors++;
                $display("FAIL idle c=%0d: got ready=%b we_n=%b oe=%b state=%0d want 1/1/0/IDLE",
                         c, ready, sram_we_n, sram_dq_oe, dut.state);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_write();
        run_access(1'b1, BASE, 32'hDEADBEEF, -1, "write_1024");
    endtask

    task automatic test_read();
        run_access(1'b0, BASE, 32'h0, -1, "read_1024");
    endtask

    task automatic test_addr_map();
        run_access(1'b1, BASE + 8, 32'h12345678, -1, "write_1032");
        run_access(1'b0, BASE + 8, 32'h0, -1, "read_1032");
        run_access(1'b0, BASE + 3, 32'h0, -1, "read_1027");
    endtask

    task automatic test_drop_request();
        run_access(1'b1, BASE + 12, 32'hA5A55A5A, 2, "write_drop");
        run_access(1'b0, BASE + 12, 32'h0, -1, "read_after_drop");
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, BASE + 4, 32'h0BADF00D, -1, "b2b_write");
        run_access(1'b0, BASE + 4, 32'h0, -1, "b2b_read");
        run_access(1'b0, BASE + 8, 32'h0, -1, "b2b_read2");
    endtask

    task automatic test_mid_reset();
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = BASE + 16;
        write_data = 32'hCAFEF00D;
        repeat (W + 3) @(posedge clk);
        #2;
        checks++;
        if (dut.state !== HIGH) begin
            errors++;
            $display("FAIL mid_reset setup state: got %0d want %0d", dut.state, HIGH);
        end
        rest  = 1'b1;
        wr_en = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset control: got we_n=%b oe=%b ready=%b want 1/0/1", sram_we_n,
                     sram_dq_oe, ready);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset state: got %0d want %0d", dut.state, IDLE);
        end
        checks++;
        if (read_data !== 32'h0 || sram_addr !== '0 || sram_dq_out !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset data regs: got rd=%h addr=%0d dq=%h want 0/0/0", read_data,
                     sram_addr, sram_dq_out);
        end
        last_read = 32'h0;
        @(negedge clk);
        rest = 1'b0;
        @(posedge clk);
        #1;
        run_access(1'b0, BASE, 32'h0, -1, "read_after_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_write();
        test_read();
        test_addr_map();
        test_drop_request();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
